// File: rtl/sequencer_pkg.sv
// Shared types for the LEGv8 stage sequencer: FSM state encoding and
// the stage index of each datapath step.
package sequencer_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int STG_FETCH     = 0;
  localparam int STG_DECODE    = 1;
  localparam int STG_EXECUTE   = 2;
  localparam int STG_MEMORY    = 3;
  localparam int STG_WRITEBACK = 4;

endpackage

// File: rtl/sat_counter.sv
// Up-counter with enable and synchronous clear that sticks at all-ones
// instead of wrapping.
module sat_counter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             clear,
  input  logic             en,
  output logic [WIDTH-1:0] count
);

  always_ff @(posedge clk) begin
    if (clear) begin
      count <= '0;
    end else if (en && (count != '1)) begin
      count <= count + WIDTH'(1);
    end
  end

endmodule

// File: rtl/stage_sequencer.sv
// Single-clock sequencer issuing one-hot stage enables with programmable
// dwell, memory-wait stall, halt request, retire limit and run counters.
module stage_sequencer
  import sequencer_pkg::*;
#(
  parameter int NUM_STAGES = 5,
  parameter int DWELL      = 1,
  parameter int MEM_STAGE  = STG_MEMORY,
  parameter int CNT_WIDTH  = 32,
  parameter int MAX_INSTR  = 0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  mem_busy,
  input  logic                  halt_req,
  output logic [NUM_STAGES-1:0] stage_en,
  output logic                  stage_first,
  output logic                  retire,
  output logic                  running,
  output logic                  done,
  output logic [CNT_WIDTH-1:0]  instr_count,
  output logic [CNT_WIDTH-1:0]  cycle_count,
  output state_t                state_dbg
);

  localparam int IDX_W = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1;
  localparam int DW_W  = (DWELL > 1) ? $clog2(DWELL) : 1;

  localparam logic [IDX_W-1:0]      LAST_IDX = IDX_W'(NUM_STAGES - 1);
  localparam logic [IDX_W-1:0]      MEM_IDX  = IDX_W'(MEM_STAGE);
  localparam logic [DW_W-1:0]       LAST_DW  = DW_W'(DWELL - 1);
  localparam logic [CNT_WIDTH-1:0]  LIMIT    = CNT_WIDTH'(MAX_INSTR);
  localparam logic [NUM_STAGES-1:0] ONE_HOT0 = NUM_STAGES'(1);

  state_t           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [DW_W-1:0]  dwell_q, dwell_d;
  logic             halt_q, halt_d;
  logic             stall_q, stall_d;

  logic final_dwell;
  logic stall;
  logic limit_hit;

  // Contract: start is a level looked at only in IDLE; retire marks the
  // single cycle on which the datapath may commit PC and register writes.
  assign running     = (state_q == RUN);
  assign done        = (state_q == DONE);
  assign state_dbg   = state_q;
  assign final_dwell = (dwell_q == LAST_DW);
  assign retire      = running && (idx_q == LAST_IDX) && final_dwell;
  assign stall       = running && (idx_q == MEM_IDX) && final_dwell && mem_busy;
  assign limit_hit   = (MAX_INSTR != 0) && ((instr_count + CNT_WIDTH'(1)) == LIMIT);
  assign stage_en    = running ? (ONE_HOT0 << idx_q) : '0;
  // A held memory stage must not re-announce its first cycle.
  assign stage_first = running && (dwell_q == '0) && !stall_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      idx_q   <= '0;
      dwell_q <= '0;
      halt_q  <= 1'b0;
      stall_q <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      dwell_q <= dwell_d;
      halt_q  <= halt_d;
      stall_q <= stall_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    dwell_d = dwell_q;
    halt_d  = halt_q;
    stall_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RUN;
          idx_d   = '0;
          dwell_d = '0;
        end
      end
      RUN: begin
        if (halt_req) halt_d = 1'b1;
        if (stall) begin
          stall_d = 1'b1;
        end else if (!final_dwell) begin
          dwell_d = dwell_q + DW_W'(1);
        end else begin
          dwell_d = '0;
          idx_d   = (idx_q == LAST_IDX) ? '0 : idx_q + IDX_W'(1);
        end
        // A halt arriving on the retire cycle itself still stops here.
        if (retire && (halt_q || halt_req || limit_hit)) begin
          state_d = DONE;
          halt_d  = 1'b0;
          idx_d   = '0;
          dwell_d = '0;
        end
      end
      DONE: begin
        state_d = DONE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  sat_counter #(.WIDTH(CNT_WIDTH)) u_instr_cnt (
    .clk   (clk),
    .clear (reset),
    .en    (retire),
    .count (instr_count)
  );

  sat_counter #(.WIDTH(CNT_WIDTH)) u_cycle_cnt (
    .clk   (clk),
    .clear (reset),
    .en    (running),
    .count (cycle_count)
  );

endmodule

// File: tb/tb_stage_sequencer.sv
// Directed bench for stage_sequencer: default build plus a DWELL=2,
// MAX_INSTR=3 build, checked against an expected-output queue.
module tb_stage_sequencer;
  import sequencer_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        d_reset, d_start, d_mem, d_halt;
  logic [4:0]  d_stage_en;
  logic        d_stage_first, d_retire, d_running, d_done;
  logic [31:0] d_instr, d_cycle;
  state_t      d_state;

  logic        w_reset, w_start, w_mem, w_halt;
  logic [4:0]  w_stage_en;
  logic        w_stage_first, w_retire, w_running, w_done;
  logic [31:0] w_instr, w_cycle;
  state_t      w_state;

  stage_sequencer u_dflt (
    .clk         (clk),
    .reset       (d_reset),
    .start       (d_start),
    .mem_busy    (d_mem),
    .halt_req    (d_halt),
    .stage_en    (d_stage_en),
    .stage_first (d_stage_first),
    .retire      (d_retire),
    .running     (d_running),
    .done        (d_done),
    .instr_count (d_instr),
    .cycle_count (d_cycle),
    .state_dbg   (d_state)
  );

  stage_sequencer #(.DWELL(2), .MAX_INSTR(3)) u_dw2 (
    .clk         (clk),
    .reset       (w_reset),
    .start       (w_start),
    .mem_busy    (w_mem),
    .halt_req    (w_halt),
    .stage_en    (w_stage_en),
    .stage_first (w_stage_first),
    .retire      (w_retire),
    .running     (w_running),
    .done        (w_done),
    .instr_count (w_instr),
    .cycle_count (w_cycle),
    .state_dbg   (w_state)
  );

  int checks   = 0;
  int failures = 0;

  // {stage_en, stage_first, retire, running, done}
  logic [8:0] exp_q[$];
  localparam logic [8:0] DONE_VEC = 9'b00000_0_0_0_1;

  function automatic logic [8:0] d_obs();
    return {d_stage_en, d_stage_first, d_retire, d_running, d_done};
  endfunction

  function automatic logic [8:0] w_obs();
    return {w_stage_en, w_stage_first, w_retire, w_running, w_done};
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic d_restart();
    d_reset = 1'b1;
    tick();
    d_reset = 1'b0;
    d_start = 1'b1;
    tick();
    d_start = 1'b0;
  endtask

  task automatic push_plain(input int n);
    logic [4:0] se;
    for (int k = 0; k < n; k++) begin
      se = 5'b00001 << (k % 5);
      exp_q.push_back({se, 1'b1, (k % 5) == 4, 1'b1, 1'b0});
    end
  endtask

  initial begin
    logic [8:0] e;
    logic [4:0] mem_se[9];
    logic       mem_first[9];

    d_reset = 1'b1; d_start = 1'b0; d_mem = 1'b0; d_halt = 1'b0;
    w_reset = 1'b1; w_start = 1'b0; w_mem = 1'b0; w_halt = 1'b0;
    repeat (3) tick();
    d_reset = 1'b0;

    // Idle after reset with start low
    for (int i = 0; i < 5; i++) begin
      check("idle_outs", d_obs(), 9'b0);
      check("idle_cnt", {d_instr, d_cycle}, 64'd0);
      check("idle_state", d_state, IDLE);
      tick();
    end

    // Free run, unlimited
    d_start = 1'b1;
    tick();
    d_start = 1'b0;
    push_plain(20);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("run_seq", d_obs(), e);
      tick();
    end
    check("run_instr", d_instr, 32'd4);
    check("run_cycle", d_cycle, 32'd20);

    // Memory stall: busy in decode is ignored, busy 3 cycles in memory
    mem_se    = '{5'b00001, 5'b00010, 5'b00100, 5'b01000, 5'b01000,
                  5'b01000, 5'b01000, 5'b10000, 5'b00001};
    mem_first = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    d_restart();
    for (int k = 0; k < 9; k++)
      exp_q.push_back({mem_se[k], mem_first[k], k == 7, 1'b1, 1'b0});
    for (int k = 0; k < 9; k++) begin
      d_mem = (k == 1) || (k >= 3 && k <= 5);
      e = exp_q.pop_front();
      check("mem_seq", d_obs(), e);
      tick();
    end
    d_mem = 1'b0;
    check("mem_instr", d_instr, 32'd1);
    check("mem_cycle", d_cycle, 32'd9);

    // Halt during execute of instruction 2
    d_restart();
    push_plain(10);
    for (int k = 0; k < 10; k++) begin
      d_halt = (k == 7);
      e = exp_q.pop_front();
      check("halt_seq", d_obs(), e);
      tick();
    end
    d_halt = 1'b0;
    check("halt_done", d_obs(), DONE_VEC);
    check("halt_instr", d_instr, 32'd2);
    check("halt_cycle", d_cycle, 32'd10);
    check("halt_state", d_state, DONE);
    d_start = 1'b1;
    tick();
    d_start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check("done_hold", d_obs(), DONE_VEC);
      check("done_instr", d_instr, 32'd2);
      tick();
    end

    // Halt on the retire cycle itself
    d_restart();
    push_plain(5);
    for (int k = 0; k < 5; k++) begin
      d_halt = (k == 4);
      e = exp_q.pop_front();
      check("halt_ret_seq", d_obs(), e);
      tick();
    end
    d_halt = 1'b0;
    check("halt_ret_done", d_obs(), DONE_VEC);
    check("halt_ret_instr", d_instr, 32'd1);
    check("halt_ret_cycle", d_cycle, 32'd5);

    // Reset mid-execute of instruction 1
    d_restart();
    tick();
    tick();
    check("pre_rst_exec", d_obs(), {5'b00100, 1'b1, 1'b0, 1'b1, 1'b0});
    d_reset = 1'b1;
    tick();
    check("rst_outs", d_obs(), 9'b0);
    check("rst_cnt", {d_instr, d_cycle}, 64'd0);
    check("rst_state", d_state, IDLE);
    d_reset = 1'b0;
    d_start = 1'b1;
    tick();
    d_start = 1'b0;
    check("restart_fetch", d_obs(), {5'b00001, 1'b1, 1'b0, 1'b1, 1'b0});

    // DWELL=2 with a 3-instruction limit
    w_reset = 1'b0;
    tick();
    check("w_idle", w_obs(), 9'b0);
    w_start = 1'b1;
    tick();
    w_start = 1'b0;
    for (int k = 0; k < 30; k++) begin
      logic [4:0] se;
      se = 5'b00001 << ((k / 2) % 5);
      exp_q.push_back({se, (k % 2) == 0, (k % 10) == 9, 1'b1, 1'b0});
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("w_seq", w_obs(), e);
      tick();
    end
    check("w_done", w_obs(), DONE_VEC);
    check("w_instr", w_instr, 32'd3);
    check("w_cycle", w_cycle, 32'd30);
    tick();
    check("w_done_hold", w_obs(), DONE_VEC);
    check("w_cycle_hold", w_cycle, 32'd30);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
